// File: rtl/mmu_dport_arb_pkg.sv
// Shared definitions for the multi-port MMU data-port arbiter.
// Holds the response-FIFO entry type and the port-count limits.
package mmu_dport_arb_pkg;

  // Largest supported number of LSU data ports.
  localparam int MMU_DPORT_MAX  = 8;
  // Port-id width sized for MMU_DPORT_MAX ports.
  localparam int DPORT_PIDW_MAX = 3;

  // One in-flight request: which port it belongs to, and whether it was
  // completed locally (translation fault) instead of going to the dcache.
  typedef struct packed {
    logic [DPORT_PIDW_MAX-1:0] pid;
    logic                      bypass;
  } dport_resp_t;

endpackage

// File: rtl/mmu_resp_fifo.sv
// In-order response FIFO. Simultaneous push and pop are supported.
// A push while full or a pop while empty is ignored.
module mmu_resp_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // The extra MSB on each pointer tells full apart from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset drops every stored entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents do not need a reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmu_dport_arb.sv
// Round-robin arbiter that serialises NPORT LSU data channels onto one
// dcache request/response interface and routes responses back in order.
// Requests that carry a translation fault are completed locally (bypass).
// Optional feature macro: MMU_DPORT_PERF_EN enables the perf counters.
//
// Handshake: a port holds p_req and its fields stable until it sees p_addr_ok
// in the same cycle; the dcache takes a request only on dcache_req &&
// dcache_addr_ok, and returns exactly one dcache_data_ok per accepted
// request, strictly in order. p_data_ok is a single-cycle response pulse.
module mmu_dport_arb
  import mmu_dport_arb_pkg::*;
#(
  parameter  int NPORT     = 2,
  parameter  int MAX_OUTST = 4,
  localparam int PIDW      = $clog2(NPORT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORT-1:0]      p_req,
  input  logic [NPORT-1:0]      p_we,
  input  logic [2*NPORT-1:0]    p_size,
  input  logic [4*NPORT-1:0]    p_wstrb,
  input  logic [32*NPORT-1:0]   p_wdata,
  input  logic [32*NPORT-1:0]   p_pa,
  input  logic [NPORT-1:0]      p_uncached,
  input  logic [NPORT-1:0]      p_fault,
  output logic [NPORT-1:0]      p_addr_ok,
  output logic [NPORT-1:0]      p_data_ok,
  output logic [32*NPORT-1:0]   p_rdata,
  output logic                  dcache_req,
  output logic                  dcache_wr,
  output logic [1:0]            dcache_size,
  output logic [3:0]            dcache_wstrb,
  output logic [31:0]           dcache_addr,
  output logic [31:0]           dcache_wdata,
  output logic                  dcache_uncached,
  input  logic                  dcache_addr_ok,
  input  logic                  dcache_data_ok,
  input  logic [31:0]           dcache_rdata,
  output logic [31:0]           perf_acc_cnt,
  output logic [31:0]           perf_stall_cnt
);

  logic [PIDW-1:0] rr_ptr;
  logic            grant_vld;
  logic [PIDW-1:0] grant_idx;
  logic            grant_fault;
  logic            fifo_full;
  logic            fifo_empty;
  dport_resp_t     head;
  dport_resp_t     push_entry;
  logic            head_is_bypass;
  logic            blocked;
  logic            fwd_req;
  logic            bypass_acc;
  logic            accept;
  logic            pop_fire;
  logic [31:0]     resp_data;

  assign head_is_bypass = !fifo_empty && head.bypass;
  assign blocked        = fifo_full || head_is_bypass;

  // Round-robin search: first requesting port at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      for (int k = 0; k < NPORT; k++) begin
        if (!grant_vld && p_req[k] && (k == (int'(rr_ptr) + i) % NPORT)) begin
          grant_vld = 1'b1;
          grant_idx = PIDW'(k);
        end
      end
    end
  end

  // Mux the granted port's request fields towards the dcache.
  always_comb begin
    grant_fault     = 1'b0;
    dcache_wr       = 1'b0;
    dcache_size     = '0;
    dcache_wstrb    = '0;
    dcache_addr     = '0;
    dcache_wdata    = '0;
    dcache_uncached = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      if (grant_idx == PIDW'(k)) begin
        grant_fault     = p_fault[k];
        dcache_wr       = p_we[k];
        dcache_size     = p_size[2*k +: 2];
        dcache_wstrb    = p_wstrb[4*k +: 4];
        dcache_addr     = p_pa[32*k +: 32];
        dcache_wdata    = p_wdata[32*k +: 32];
        dcache_uncached = p_uncached[k];
      end
    end
  end

  // Accept decision: faulting requests bypass only once the FIFO has drained,
  // so their local completion cannot overtake older dcache responses.
  always_comb begin
    fwd_req    = !reset && grant_vld && !blocked && !grant_fault;
    bypass_acc = !reset && grant_vld && !blocked && grant_fault && fifo_empty;
    accept     = (fwd_req && dcache_addr_ok) || bypass_acc;
    dcache_req = fwd_req;
    p_addr_ok  = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (grant_idx == PIDW'(k)) p_addr_ok[k] = accept;
    end
  end

  // Response routing: a bypass head retires unconditionally, otherwise wait for the dcache.
  always_comb begin
    pop_fire  = !reset && (head_is_bypass || (!fifo_empty && dcache_data_ok));
    resp_data = head_is_bypass ? 32'h0 : dcache_rdata;
    p_data_ok = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (head.pid == DPORT_PIDW_MAX'(k)) p_data_ok[k] = pop_fire;
    end
  end

  assign p_rdata = {NPORT{resp_data}};

  assign push_entry.pid    = DPORT_PIDW_MAX'(grant_idx);
  assign push_entry.bypass = grant_fault;

  mmu_resp_fifo #(
    .WIDTH ($bits(dport_resp_t)),
    .DEPTH (MAX_OUTST)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop_fire),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Round-robin pointer moves past the port that was just accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(grant_idx) == NPORT - 1) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef MMU_DPORT_PERF_EN
  logic [31:0] acc_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters: accepts and cycles where a request waits on a blocked queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept)              acc_cnt_q   <= acc_cnt_q + 32'd1;
      if (|p_req && blocked)   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_acc_cnt   = acc_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_acc_cnt   = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

`ifndef SYNTHESIS
  // Responses still in flight when reset hit may arrive afterwards; they are
  // tolerated until the first new accept, after which a stray response is an error.
  logic resp_grace_q;

  // Track the post-reset window in which late responses are expected.
  always_ff @(posedge clk) begin
    if (reset)       resp_grace_q <= 1'b1;
    else if (accept) resp_grace_q <= 1'b0;
  end

  // Flag a dcache response that has no matching in-flight request.
  always @(posedge clk) begin
    if (!reset && !resp_grace_q) begin
      assert (!(dcache_data_ok && (fifo_empty || head_is_bypass)))
        else $error("mmu_dport_arb: dcache_data_ok with no outstanding dcache request");
    end
  end
`endif

endmodule

// File: doc/mmu_dport_arb.md
Name: mmu_dport_arb

Overview:
- Parametrised successor to the single-data-port MMU back end.
- Serialises NPORT LSU data channels onto the one dcache request/response interface, using round-robin arbitration.
- Tracks up to MAX_OUTST in-flight requests in an in-order response FIFO and routes each data_ok/rdata back to its originating port.
- Requests that already carry a translation exception are not forwarded to the dcache. They are locally completed, with ordering preserved.

Parameters:
- NPORT, 2, number of LSU data ports (>=2).
- MAX_OUTST, 4, response FIFO depth (power of 2, >=2).
- PIDW, $clog2(NPORT), port-id width (derived, not overridable).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- p_req  in  NPORT  per-port request, held until p_addr_ok.
- p_we  in  NPORT  per-port write.
- p_size  in  2*NPORT  per-port size, port k at [2k+1:2k].
- p_wstrb  in  4*NPORT  per-port byte strobes.
- p_wdata  in  32*NPORT  per-port write data.
- p_pa  in  32*NPORT  per-port translated physical address.
- p_uncached  in  NPORT  per-port MAT==0.
- p_fault  in  NPORT  per-port translation exception (tlbr/pil/pis/ppi/pme OR).
- p_addr_ok  out  NPORT  one-hot accept.
- p_data_ok  out  NPORT  one-hot response.
- p_rdata  out  32*NPORT  response data; all lanes driven with the same value.
- dcache_req  out  1  request to dcache.
- dcache_wr  out  1  write.
- dcache_size  out  2  size.
- dcache_wstrb  out  4  strobes.
- dcache_addr  out  32  physical address.
- dcache_wdata  out  32  write data.
- dcache_uncached  out  1  uncached.
- dcache_addr_ok  in  1  dcache accept.
- dcache_data_ok  in  1  dcache response, strictly in order.
- dcache_rdata  in  32  dcache read data.
- perf_acc_cnt  out  32  accepted requests (see Optional Feature).
- perf_stall_cnt  out  32  blocked cycles (see Optional Feature).

Behaviour:
- Reset: rr_ptr=0, FIFO empty, counters 0. All p_addr_ok/p_data_ok/dcache_req are 0 during and after reset until a request arrives. Reset mid-transaction drops all in-flight entries; a late dcache_data_ok after reset is ignored.
- Arbitration (combinational):
  - grant = first k with p_req[k], searching from rr_ptr upward, wrapping mod NPORT.
  - blocked = fifo_full OR head_is_bypass.
  - No grant while blocked.
- Forward path, granted port k with p_fault[k]=0:
  - dcache_req=1; dcache_* fields muxed from port k.
  - p_addr_ok[k]=dcache_addr_ok.
  - The grant may change between cycles before the handshake. The dcache samples only on req&addr_ok.
- Bypass path, granted port k with p_fault[k]=1:
  - Accepted only when the FIFO is empty; dcache_req=0; p_addr_ok[k]=1 immediately.
  - Pushes entry {pid=k, bypass=1}.
- Push: on any accept, entry {pid, bypass}. After an accept to port k, rr_ptr <= (k+1) mod NPORT; otherwise rr_ptr holds.
- Pop, non-bypass head: on dcache_data_ok; p_data_ok[head.pid]=1, p_rdata=dcache_rdata, same cycle.
- Pop, bypass head: unconditionally the cycle after push; p_data_ok[pid]=1, p_rdata=0. No grant that cycle.
- Push and pop in the same cycle are allowed when not full. Occupancy is unchanged.
- Full: no accept even if a pop occurs that cycle.
- dcache_data_ok with the FIFO empty or a bypass head is a protocol error. It is ignored, and a simulation assertion fires.
- Latency: addr_ok is combinational from p_req/dcache_addr_ok. data_ok is combinational from dcache_data_ok. Bypass data_ok comes 1 cycle after accept.

Optional Feature:
- Macro MMU_DPORT_PERF_EN.
- Defined:
  - perf_acc_cnt increments on every accept.
  - perf_stall_cnt increments on each cycle with |p_req && blocked.
  - Both 32-bit, wrap at 2^32-1 -> 0, cleared by reset.
- Undefined: both outputs are tied to 32'h0 and no counter flops are present.

Decomposition:
- Shared definitions header gets:
  - typedef dport_resp_t {logic [PIDW-1:0] pid; logic bypass;} (PIDW supplied via parameterised width or max-size constant DPORT_PIDW_MAX=3).
  - constant MMU_DPORT_MAX=8.
- One sub-module, mmu_resp_fifo: synchronous FIFO with WIDTH and DEPTH parameters, push/pop/full/empty/head, simultaneous push/pop supported.

Test Plan:
- NPORT=2; ports 0 and 1 both req loads from reset; dcache_addr_ok=1 -> port 0 accepted first, port 1 next. Two dcache_data_ok with rdata 0x11, 0x22 -> p_data_ok[0]=1 with 0x11, then p_data_ok[1]=1 with 0x22.
- MAX_OUTST=4; port 0 issues 5 loads, no dcache_data_ok -> 4 accepts, 5th blocked. One data_ok -> 5th accepted the next cycle; perf_stall_cnt>=1 with macro.
- Port 1 faults (p_fault=1) with the FIFO empty -> p_addr_ok[1]=1, dcache_req=0. Next cycle p_data_ok[1]=1, p_rdata=0, and no grant that cycle.
- Port 1 faults while one port-0 load is outstanding -> no accept for port 1. After port-0 data_ok, port 1 is accepted as bypass.
- Reset asserted with 2 entries outstanding -> FIFO empty, rr_ptr=0. A following stray dcache_data_ok produces no p_data_ok.
- NPORT=4, all req continuously, immediate addr_ok -> grant order 0,1,2,3,0.
